// File: rtl/md5_stream_engine_pkg.sv
// Shared MD5 constants, per-step helper functions and the engine state type.
package md5_stream_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S_TAB [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] md5_f(input logic [1:0] round, input logic [31:0] b, c, d);
    case (round)
      2'd0:    return (b & c) | (~b & d);
      2'd1:    return (d & b) | (~d & c);
      2'd2:    return b ^ c ^ d;
      default: return c ^ (b | ~d);
    endcase
  endfunction

  // Message word index; only the low 4 bits matter, so 8-bit wrap is harmless.
  function automatic logic [3:0] md5_g(input logic [5:0] step);
    logic [7:0] s8;
    logic [7:0] g8;
    s8 = {2'b00, step};
    case (step[5:4])
      2'd0:    g8 = s8;
      2'd1:    g8 = s8 * 8'd5 + 8'd1;
      2'd2:    g8 = s8 * 8'd3 + 8'd5;
      default: g8 = s8 * 8'd7;
    endcase
    return g8[3:0];
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] dbl;
    dbl = {x, x} << s;
    return dbl[63:32];
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_stream_engine_step.sv
// One combinational MD5 step: rotates the A/B/C/D working set by one position.
module md5_stream_engine_step
  import md5_stream_engine_pkg::*;
(
  input  logic [1:0]  round,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [31:0] k,
  input  logic [4:0]  s,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n,
  output logic [31:0] d_n
);

  logic [31:0] sum;

  assign sum = a + md5_f(round, b, c, d) + k + m;
  assign a_n = d;
  assign b_n = b + rotl32(sum, s);
  assign c_n = b;
  assign d_n = c;

endmodule

// File: rtl/md5_stream_engine.sv
// Multi-block MD5 engine: chains A..D across pre-padded blocks, R steps per clock.
//
// state    | meaning
// ST_IDLE  | ready for a block; capture and seed working regs on transfer
// ST_RUN   | evaluate ROUNDS_PER_CYCLE steps per clock until all 64 done
// ST_FINAL | fold working regs into chain; latch digest if last block
// ST_OUT   | hold digest until consumer accepts; chain returns to IV
module md5_stream_engine
  import md5_stream_engine_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int STEP_CNT_W       = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [127:0] digest,
  output logic         busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
    $error("md5_stream_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  if (STEP_CNT_W != 6) begin : g_bad_width
    $error("md5_stream_engine: STEP_CNT_W must be 6");
  end

  state_t                  state, state_n;
  logic [STEP_CNT_W-1:0]   step_q;
  logic                    last_q;
  logic                    last_step;
  logic [31:0]             msg [16];
  logic [31:0]             wa, wb, wc, wd;
  logic [31:0]             ca, cb, cc, cd;
  logic [31:0]             sa [R+1];
  logic [31:0]             sb [R+1];
  logic [31:0]             sc [R+1];
  logic [31:0]             sd [R+1];

  assign sa[0] = wa;
  assign sb[0] = wb;
  assign sc[0] = wc;
  assign sd[0] = wd;

  for (genvar k = 0; k < R; k++) begin : g_step
    logic [5:0] idx;
    assign idx = step_q + STEP_CNT_W'(k);
    md5_stream_engine_step u_step (
      .round (idx[5:4]),
      .a     (sa[k]),
      .b     (sb[k]),
      .c     (sc[k]),
      .d     (sd[k]),
      .m     (msg[md5_g(idx)]),
      .k     (K_TAB[idx]),
      .s     (S_TAB[idx]),
      .a_n   (sa[k+1]),
      .b_n   (sb[k+1]),
      .c_n   (sc[k+1]),
      .d_n   (sd[k+1])
    );
  end

  assign last_step = ({1'b0, step_q} + (STEP_CNT_W+1)'(R)) == (STEP_CNT_W+1)'(64);
  assign blk_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (blk_valid) state_n = ST_RUN;
      ST_RUN:   if (last_step) state_n = ST_FINAL;
      ST_FINAL: state_n = last_q ? ST_OUT : ST_IDLE;
      ST_OUT:   if (dig_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Datapath: capture, step iteration, chain update and digest output.
  // A first block reloads the chain from IV at capture so FINAL can always add chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q    <= '0;
      last_q    <= 1'b0;
      wa <= '0; wb <= '0; wc <= '0; wd <= '0;
      ca <= IV_A; cb <= IV_B; cc <= IV_C; cd <= IV_D;
      dig_valid <= 1'b0;
      digest    <= '0;
      for (int j = 0; j < 16; j++) msg[j] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blk_valid) begin
            for (int j = 0; j < 16; j++) msg[j] <= bswap32(blk_data[511-32*j -: 32]);
            step_q <= '0;
            last_q <= blk_last;
            if (blk_first) begin
              ca <= IV_A; cb <= IV_B; cc <= IV_C; cd <= IV_D;
              wa <= IV_A; wb <= IV_B; wc <= IV_C; wd <= IV_D;
            end else begin
              wa <= ca; wb <= cb; wc <= cc; wd <= cd;
            end
          end
        end
        ST_RUN: begin
          wa <= sa[R]; wb <= sb[R]; wc <= sc[R]; wd <= sd[R];
          step_q <= step_q + STEP_CNT_W'(R);
        end
        ST_FINAL: begin
          ca <= ca + wa; cb <= cb + wb; cc <= cc + wc; cd <= cd + wd;
          if (last_q) begin
            digest    <= {bswap32(ca + wa), bswap32(cb + wb), bswap32(cc + wc), bswap32(cd + wd)};
            dig_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            ca <= IV_A; cb <= IV_B; cc <= IV_C; cd <= IV_D;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
